// File: rtl/simd_pkg.sv
// Shared SIMD array types and sizes.
// The processor and the result drain both import this package.
package simd_pkg;

  localparam int PE_COUNT   = 4;
  localparam int DATA_WIDTH = 32;
  localparam int BRAM_DEPTH = 2048;
  localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH);

  typedef logic [PE_COUNT-1:0][DATA_WIDTH-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } drain_state_t;

endpackage

// File: rtl/drain_fifo.sv
// First-word fall-through row buffer for the result drain.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module drain_fifo import simd_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = $bits(row_t) + 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= inc(wp);
      if (do_pop)  rp <= inc(rp);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/result_drain.sv
// Streams result BRAM rows out over a valid/ready port.
// Reads are issued only while the buffer can still absorb every in-flight row.
module result_drain import simd_pkg::*; #(
  parameter int PE_COUNT   = simd_pkg::PE_COUNT,
  parameter int DATA_WIDTH = simd_pkg::DATA_WIDTH,
  parameter int BRAM_DEPTH = simd_pkg::BRAM_DEPTH,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = RD_LAT + 2,
  localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  localparam int RW         = PE_COUNT * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   row_count,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [RW-1:0]         bram_dout,
  output logic [RW-1:0]         m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] MAX_ROWS = (ADDR_WIDTH + 1)'(BRAM_DEPTH);

  drain_state_t      state;
  logic [ADDR_WIDTH:0] ptr;
  logic [ADDR_WIDTH:0] rows;
  logic [RD_LAT-1:0] sr_v;
  logic [RD_LAT-1:0] sr_l;
  logic              issue;
  logic              is_last;
  logic              pop;
  logic              empty;
  logic [CW-1:0]     count;
  logic [RW:0]       head;

  // Credit check ignores same-cycle pops so the buffer can never overflow.
  assign issue   = (state == RUN) &&
                   (int'($countones(sr_v)) + int'(count) < FIFO_DEPTH);
  assign is_last = (ptr == rows - 1'b1);

  assign bram_en   = issue;
  assign bram_addr = ptr[ADDR_WIDTH-1:0];
  assign m_valid   = !empty;
  assign m_data    = empty ? '0 : head[RW-1:0];
  assign m_last    = !empty && head[RW];
  assign pop       = m_valid && m_ready;
  assign busy      = (state != IDLE);

  drain_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (RW + 1),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (sr_v[RD_LAT-1]),
    .din   ({sr_l[RD_LAT-1], bram_dout}),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ptr   <= '0;
      rows  <= '0;
      sr_v  <= '0;
      sr_l  <= '0;
      done  <= 1'b0;
    end else begin
      sr_v <= (sr_v << 1) | RD_LAT'(issue);
      sr_l <= (sr_l << 1) | RD_LAT'(issue && is_last);
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ptr <= '0;
            if (row_count == '0) begin
              state <= DONE;
            end else begin
              rows  <= (row_count > MAX_ROWS) ? MAX_ROWS : row_count;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            ptr <= ptr + 1'b1;
            if (is_last) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && m_last) state <= DONE;
        end
        DONE: begin
          // First DONE cycle arms the pulse, second emits it.
          if (!done) done  <= 1'b1;
          else       state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
